instr_encoder: RTL

//   Inverse of the decode-side immediate extraction: packs opcode, register, funct and

---
 rtl/instr_encoder_pkg.sv | 22 ++
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder_field_pack.sv | 39 +++
 rtl/instr_encoder.sv | 87 ++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32 instruction encoder: format codes and opcodes.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'b00,
    FMT_I = 2'b01,
    FMT_S = 2'b10,
    FMT_U = 2'b11
  } fmt_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  // I/S immediates fit in 12 signed bits when bits 31..11 are all copies of the sign.
  function automatic logic imm12_fits(input logic [31:0] imm);
    return (&imm[31:11]) || (~|imm[31:11]);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake and encoded-word output handshake of the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  // Sequencer side: produces bundles, consumes words.
  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder_field_pack.sv
// Combinational packer: format + fields -> 32-bit RV32 word and immediate legality.
module enc_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        imm_legal_o
);

  // Place fields per format; out-of-range immediates are simply truncated here.
  always_comb begin
    word_o      = 32'h0;
    imm_legal_o = 1'b1;
    case (fmt_e'(fmt_i))
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: begin
        word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        imm_legal_o = imm12_fits(imm_i);
      end
      FMT_S: begin
        word_o      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        imm_legal_o = imm12_fits(imm_i);
      end
      FMT_U: begin
        word_o      = {imm_i[31:12], rd_i, opcode_i};
        imm_legal_o = (imm_i[11:0] == 12'h000);
      end
      default: word_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: one output register, byte-address tagging, error count.
// Optional build macro ENCODER_RANGE_CHECK_EN: out-of-range immediates are consumed
// but dropped and counted in err_cnt; without it they are truncated and err_cnt is 0.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  instr_encoder_if.slave     bus,
  output logic [7:0]         err_cnt
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic [31:0]       word;
  logic              imm_legal;
  logic              fire_in;
  logic              load;

  enc_field_pack u_pack (
    .fmt_i       (bus.in_fmt),
    .opcode_i    (bus.in_opcode),
    .rd_i        (bus.in_rd),
    .rs1_i       (bus.in_rs1),
    .rs2_i       (bus.in_rs2),
    .funct3_i    (bus.in_funct3),
    .funct7_i    (bus.in_funct7),
    .imm_i       (bus.in_imm),
    .word_o      (word),
    .imm_legal_o (imm_legal)
  );

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign fire_in       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;

`ifdef ENCODER_RANGE_CHECK_EN
  logic [7:0] err_cnt_q;

  assign load    = fire_in && imm_legal;
  assign err_cnt = err_cnt_q;

  // Count consumed-but-dropped bundles, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if (fire_in && !imm_legal && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`else
  logic unused_legal;

  assign load         = fire_in;
  assign err_cnt      = 8'd0;
  assign unused_legal = imm_legal;
`endif

  // Output register and address counter; a capture overrides the drain so a
  // simultaneous output handshake and new load sustains one word per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_addr_q  <= BASE;
      next_addr_q <= BASE;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_instr_q <= word;
      out_addr_q  <= next_addr_q;
      next_addr_q <= next_addr_q + STEP;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
